// File: rtl/sata_pim_arb.sv
// sata_pim_arb: round-robin owner of one MPMC PIM port shared by SATA DMA engines.
// Optional grant-hold watchdog: define SATA_PIM_ARB_TIMEOUT_EN.
module sata_pim_arb #(
    parameter int C_NUM_PORTS = 2,
    parameter int C_TIMEOUT   = 4095
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic [C_NUM_PORTS-1:0]    arb_req,
    output logic [C_NUM_PORTS-1:0]    arb_gnt,
    input  logic [32*C_NUM_PORTS-1:0] req_Addr,
    input  logic [C_NUM_PORTS-1:0]    req_AddrReq,
    input  logic [C_NUM_PORTS-1:0]    req_RNW,
    input  logic [4*C_NUM_PORTS-1:0]  req_Size,
    input  logic [C_NUM_PORTS-1:0]    req_RdModWr,
    input  logic [C_NUM_PORTS-1:0]    req_RdFIFO_Pop,
    input  logic [C_NUM_PORTS-1:0]    req_RdFIFO_Flush,
    input  logic [32*C_NUM_PORTS-1:0] req_WrFIFO_Data,
    input  logic [4*C_NUM_PORTS-1:0]  req_WrFIFO_BE,
    input  logic [C_NUM_PORTS-1:0]    req_WrFIFO_Push,
    input  logic [C_NUM_PORTS-1:0]    req_WrFIFO_Flush,
    output logic [C_NUM_PORTS-1:0]    req_AddrAck,
    output logic [C_NUM_PORTS-1:0]    req_RdFIFO_Empty,
    output logic [C_NUM_PORTS-1:0]    req_WrFIFO_AlmostFull,
    output logic [31:0]               req_RdFIFO_Data,
    output logic [31:0]               PIM_Addr,
    output logic                      PIM_AddrReq,
    output logic                      PIM_RNW,
    output logic [3:0]                PIM_Size,
    output logic                      PIM_RdModWr,
    output logic                      PIM_RdFIFO_Pop,
    output logic                      PIM_RdFIFO_Flush,
    output logic [31:0]               PIM_WrFIFO_Data,
    output logic [3:0]                PIM_WrFIFO_BE,
    output logic                      PIM_WrFIFO_Push,
    output logic                      PIM_WrFIFO_Flush,
    input  logic                      PIM_AddrAck,
    input  logic                      PIM_RdFIFO_Empty,
    input  logic                      PIM_WrFIFO_Empty,
    input  logic                      PIM_WrFIFO_AlmostFull,
    input  logic                      PIM_InitDone,
    input  logic [31:0]               PIM_RdFIFO_Data,
    output logic [31:0]               arb_state
);

    localparam int N = C_NUM_PORTS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t         state_q;
    logic [1:0]     owner_q;
    logic [1:0]     ptr_q;
    logic [N-1:0]   gnt_q;
    logic [7:0]     ack_cnt_q;
    logic           gap_first_q;
    logic           sticky_flush_q;
    logic           sticky_to;
    logic           to_hit;
    logic [N-1:0]   blocked;
    logic [N-1:0]   elig;
    logic [N-1:0]   win_1hot;
    logic [1:0]     win;
    logic           win_ok;
    logic           idle_cyc;

    function automatic logic [1:0] rr_idx(input logic [1:0] p, input int k);
        int j;
        j = int'(p) + k;
        if (j >= N) j = j - N;
        return 2'(j);
    endfunction

    assign elig = arb_req & ~blocked;

    // first eligible requester at or above the pointer, wrapping
    always_comb begin
        win      = '0;
        win_ok   = 1'b0;
        win_1hot = '0;
        for (int k = 0; k < N; k++) begin
            if (!win_ok && elig[rr_idx(ptr_q, k)]) begin
                win_ok = 1'b1;
                win    = rr_idx(ptr_q, k);
            end
        end
        for (int i = 0; i < N; i++) begin
            win_1hot[i] = (win == 2'(i));
        end
    end

    // owner passthrough in GRANT; only flush strobes may be high in GAP
    always_comb begin
        PIM_Addr         = '0;
        PIM_AddrReq      = 1'b0;
        PIM_RNW          = 1'b0;
        PIM_Size         = '0;
        PIM_RdModWr      = 1'b0;
        PIM_RdFIFO_Pop   = 1'b0;
        PIM_RdFIFO_Flush = 1'b0;
        PIM_WrFIFO_Data  = '0;
        PIM_WrFIFO_BE    = '0;
        PIM_WrFIFO_Push  = 1'b0;
        PIM_WrFIFO_Flush = 1'b0;
        if (state_q == GRANT) begin
            PIM_Addr         = req_Addr[32*owner_q +: 32];
            PIM_AddrReq      = req_AddrReq[owner_q];
            PIM_RNW          = req_RNW[owner_q];
            PIM_Size         = req_Size[4*owner_q +: 4];
            PIM_RdModWr      = req_RdModWr[owner_q];
            PIM_RdFIFO_Pop   = req_RdFIFO_Pop[owner_q];
            PIM_RdFIFO_Flush = req_RdFIFO_Flush[owner_q];
            PIM_WrFIFO_Data  = req_WrFIFO_Data[32*owner_q +: 32];
            PIM_WrFIFO_BE    = req_WrFIFO_BE[4*owner_q +: 4];
            PIM_WrFIFO_Push  = req_WrFIFO_Push[owner_q];
            PIM_WrFIFO_Flush = req_WrFIFO_Flush[owner_q];
        end else if (state_q == GAP && gap_first_q) begin
            PIM_RdFIFO_Flush = ~PIM_RdFIFO_Empty;
            PIM_WrFIFO_Flush = ~PIM_WrFIFO_Empty;
        end
    end

    // MPMC status reaches the owner only; others see a busy, empty port
    always_comb begin
        req_AddrAck           = '0;
        req_RdFIFO_Empty      = '1;
        req_WrFIFO_AlmostFull = '1;
        for (int i = 0; i < N; i++) begin
            if (state_q == GRANT && owner_q == 2'(i)) begin
                req_AddrAck[i]           = PIM_AddrAck;
                req_RdFIFO_Empty[i]      = PIM_RdFIFO_Empty;
                req_WrFIFO_AlmostFull[i] = PIM_WrFIFO_AlmostFull;
            end
        end
    end

    assign req_RdFIFO_Data = PIM_RdFIFO_Data;
    assign arb_gnt         = gnt_q;
    assign idle_cyc        = ~PIM_AddrAck & ~PIM_WrFIFO_Push & ~PIM_RdFIFO_Pop;

`ifdef SATA_PIM_ARB_TIMEOUT_EN
    logic [11:0] to_cnt_q;
    logic [N-1:0] blocked_q;
    logic         sticky_to_q;

    assign to_hit = (state_q == GRANT) && arb_req[owner_q] && idle_cyc &&
                    (to_cnt_q == 12'(C_TIMEOUT - 1));
    assign blocked   = blocked_q;
    assign sticky_to = sticky_to_q;

    // idle-grant watchdog; a timed-out port stays blocked until it drops req
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            to_cnt_q    <= '0;
            blocked_q   <= '0;
            sticky_to_q <= 1'b0;
        end else begin
            if (state_q != GRANT) to_cnt_q <= '0;
            else if (idle_cyc && to_cnt_q != 12'hFFF) to_cnt_q <= to_cnt_q + 12'd1;
            blocked_q <= (blocked_q & arb_req) | (to_hit ? gnt_q : '0);
            if (to_hit) sticky_to_q <= 1'b1;
        end
    end
`else
    assign to_hit    = 1'b0;
    assign blocked   = '0;
    assign sticky_to = 1'b0;
`endif

    // arbitration, ownership and post-release cleanup sequencing
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q        <= IDLE;
            owner_q        <= '0;
            ptr_q          <= '0;
            gnt_q          <= '0;
            ack_cnt_q      <= '0;
            gap_first_q    <= 1'b0;
            sticky_flush_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (PIM_InitDone && win_ok) begin
                        gnt_q     <= win_1hot;
                        owner_q   <= win;
                        ptr_q     <= rr_idx(win, 1);
                        ack_cnt_q <= '0;
                        state_q   <= GRANT;
                    end
                end
                GRANT: begin
                    if (PIM_AddrAck && ack_cnt_q != 8'hFF) ack_cnt_q <= ack_cnt_q + 8'd1;
                    if (!arb_req[owner_q] || to_hit) begin
                        gnt_q       <= '0;
                        gap_first_q <= 1'b1;
                        state_q     <= GAP;
                    end
                end
                GAP: begin
                    gap_first_q <= 1'b0;
                    if (gap_first_q && (!PIM_RdFIFO_Empty || !PIM_WrFIFO_Empty))
                        sticky_flush_q <= 1'b1;
                    if (PIM_RdFIFO_Empty && PIM_WrFIFO_Empty) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign arb_state = {14'd0, sticky_to, sticky_flush_q, ack_cnt_q,
                        2'd0, owner_q, 2'd0, state_q};

endmodule

// File: tb/tb_sata_pim_arb.sv
// tb_sata_pim_arb: self-checking bench for the shared PIM port arbiter.
// Timeout scenario compiled only with SATA_PIM_ARB_TIMEOUT_EN.
module tb_sata_pim_arb;

    localparam int N = 2;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [1:0]  arb_req, arb_gnt;
    logic [63:0] req_Addr, req_WrFIFO_Data;
    logic [1:0]  req_AddrReq, req_RNW, req_RdModWr, req_RdFIFO_Pop;
    logic [1:0]  req_RdFIFO_Flush, req_WrFIFO_Push, req_WrFIFO_Flush;
    logic [7:0]  req_Size, req_WrFIFO_BE;
    logic [1:0]  req_AddrAck, req_RdFIFO_Empty, req_WrFIFO_AlmostFull;
    logic [31:0] req_RdFIFO_Data;
    logic [31:0] PIM_Addr, PIM_WrFIFO_Data, PIM_RdFIFO_Data, arb_state;
    logic        PIM_AddrReq, PIM_RNW, PIM_RdModWr, PIM_RdFIFO_Pop;
    logic        PIM_RdFIFO_Flush, PIM_WrFIFO_Push, PIM_WrFIFO_Flush;
    logic [3:0]  PIM_Size, PIM_WrFIFO_BE;
    logic        PIM_AddrAck, PIM_RdFIFO_Empty, PIM_WrFIFO_Empty;
    logic        PIM_WrFIFO_AlmostFull, PIM_InitDone;

    int total = 0;
    int bad   = 0;
    int ptr_m = 0;

    always #5 sys_clk = ~sys_clk;

    sata_pim_arb #(.C_NUM_PORTS(N), .C_TIMEOUT(16)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .arb_req(arb_req), .arb_gnt(arb_gnt),
        .req_Addr(req_Addr), .req_AddrReq(req_AddrReq), .req_RNW(req_RNW),
        .req_Size(req_Size), .req_RdModWr(req_RdModWr),
        .req_RdFIFO_Pop(req_RdFIFO_Pop), .req_RdFIFO_Flush(req_RdFIFO_Flush),
        .req_WrFIFO_Data(req_WrFIFO_Data), .req_WrFIFO_BE(req_WrFIFO_BE),
        .req_WrFIFO_Push(req_WrFIFO_Push), .req_WrFIFO_Flush(req_WrFIFO_Flush),
        .req_AddrAck(req_AddrAck), .req_RdFIFO_Empty(req_RdFIFO_Empty),
        .req_WrFIFO_AlmostFull(req_WrFIFO_AlmostFull),
        .req_RdFIFO_Data(req_RdFIFO_Data),
        .PIM_Addr(PIM_Addr), .PIM_AddrReq(PIM_AddrReq), .PIM_RNW(PIM_RNW),
        .PIM_Size(PIM_Size), .PIM_RdModWr(PIM_RdModWr),
        .PIM_RdFIFO_Pop(PIM_RdFIFO_Pop), .PIM_RdFIFO_Flush(PIM_RdFIFO_Flush),
        .PIM_WrFIFO_Data(PIM_WrFIFO_Data), .PIM_WrFIFO_BE(PIM_WrFIFO_BE),
        .PIM_WrFIFO_Push(PIM_WrFIFO_Push), .PIM_WrFIFO_Flush(PIM_WrFIFO_Flush),
        .PIM_AddrAck(PIM_AddrAck), .PIM_RdFIFO_Empty(PIM_RdFIFO_Empty),
        .PIM_WrFIFO_Empty(PIM_WrFIFO_Empty),
        .PIM_WrFIFO_AlmostFull(PIM_WrFIFO_AlmostFull),
        .PIM_InitDone(PIM_InitDone), .PIM_RdFIFO_Data(PIM_RdFIFO_Data),
        .arb_state(arb_state)
    );

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_inputs;
        arb_req = '0; req_Addr = '0; req_WrFIFO_Data = '0;
        req_AddrReq = '0; req_RNW = '0; req_RdModWr = '0;
        req_RdFIFO_Pop = '0; req_RdFIFO_Flush = '0;
        req_WrFIFO_Push = '0; req_WrFIFO_Flush = '0;
        req_Size = '0; req_WrFIFO_BE = '0;
        PIM_AddrAck = 0; PIM_RdFIFO_Empty = 1; PIM_WrFIFO_Empty = 1;
        PIM_WrFIFO_AlmostFull = 0; PIM_InitDone = 1;
        PIM_RdFIFO_Data = $urandom;
    endtask

    task automatic do_reset;
        clear_inputs();
        sys_rst_n = 0;
        tick(); tick();
        sys_rst_n = 1;
        ptr_m = 0;
    endtask

    // reference round-robin choice: first requester at or after ptr
    function automatic int rr_pick(input logic [1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic test_reset;
        clear_inputs();
        req_AddrReq = 2'b11; req_Addr = 64'hFFFF_FFFF_FFFF_FFFF;
        sys_rst_n = 0;
        #3;
        total++; if (arb_gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b want=00", arb_gnt); end
        total++; if (PIM_AddrReq !== 1'b0 || PIM_Addr !== 32'h0) begin bad++; $display("FAIL reset_pim got=%b/%h want=0/0", PIM_AddrReq, PIM_Addr); end
        total++; if (req_RdFIFO_Empty !== 2'b11) begin bad++; $display("FAIL reset_rdempty got=%b want=11", req_RdFIFO_Empty); end
        total++; if (req_WrFIFO_AlmostFull !== 2'b11) begin bad++; $display("FAIL reset_afull got=%b want=11", req_WrFIFO_AlmostFull); end
        total++; if (req_AddrAck !== 2'b00) begin bad++; $display("FAIL reset_ack got=%b want=00", req_AddrAck); end
        total++; if (arb_state !== 32'h0) begin bad++; $display("FAIL reset_state got=%h want=0", arb_state); end
        tick();
        sys_rst_n = 1;
        clear_inputs();
    endtask

    task automatic test_basic_grant;
        do_reset();
        PIM_InitDone = 0;
        arb_req = 2'b01;
        repeat (3) tick();
        total++; if (arb_gnt !== 2'b00) begin bad++; $display("FAIL initdone_block got=%b want=00", arb_gnt); end
        PIM_InitDone = 1;
        tick();
        total++; if (arb_gnt !== 2'b01) begin bad++; $display("FAIL basic_gnt got=%b want=01", arb_gnt); end
        req_Addr = {32'hDEAD_BEEF, 32'h1000_0000};
        req_AddrReq = 2'b01; PIM_AddrAck = 1; PIM_RdFIFO_Data = 32'hA5A5_0001;
        #1;
        total++; if (PIM_Addr !== 32'h1000_0000) begin bad++; $display("FAIL basic_addr got=%h want=10000000", PIM_Addr); end
        total++; if (req_AddrAck !== 2'b01) begin bad++; $display("FAIL basic_ack got=%b want=01", req_AddrAck); end
        total++; if (req_RdFIFO_Data !== 32'hA5A5_0001) begin bad++; $display("FAIL basic_rddata got=%h want=a5a50001", req_RdFIFO_Data); end
        tick();
        PIM_AddrAck = 0; req_AddrReq = 0; arb_req = 0;
        total++; if (arb_state[15:8] !== 8'd1 || arb_state[1:0] !== 2'd1) begin bad++; $display("FAIL basic_state got=%h want cnt=1 fsm=1", arb_state); end
        tick();
        total++; if (arb_gnt !== 2'b00 || arb_state[1:0] !== 2'd2) begin bad++; $display("FAIL basic_release got=%b/%0d want=00/2", arb_gnt, arb_state[1:0]); end
        tick();
        total++; if (arb_state[1:0] !== 2'd0) begin bad++; $display("FAIL basic_idle got=%0d want=0", arb_state[1:0]); end
    endtask

    task automatic test_alternate;
        logic [1:0] exp_g [3] = '{2'b01, 2'b10, 2'b01};
        do_reset();
        arb_req = 2'b11;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 8 && arb_gnt == 2'b00; c++) tick();
            total++; if (arb_gnt !== exp_g[r]) begin bad++; $display("FAIL alt_gnt%0d got=%b want=%b", r, arb_gnt, exp_g[r]); end
            PIM_AddrAck = 1; tick(); PIM_AddrAck = 0;
            arb_req = ~exp_g[r];
            tick();
            total++; if (arb_state[1:0] !== 2'd2) begin bad++; $display("FAIL alt_gap%0d got=%0d want=2", r, arb_state[1:0]); end
            arb_req = 2'b11;
            tick();
            total++; if (arb_state[1:0] !== 2'd0 || arb_gnt !== 2'b00) begin bad++; $display("FAIL alt_onegap%0d got=%0d/%b want=0/00", r, arb_state[1:0], arb_gnt); end
        end
        arb_req = 0;
        repeat (3) tick();
    endtask

    task automatic test_random_rr;
        logic [1:0] pat, exp_af;
        int w, nack;
        logic v;
        do_reset();
        for (int it = 0; it < 12; it++) begin
            pat = 2'($urandom_range(1, 3));
            arb_req = pat;
            for (int c = 0; c < 8 && arb_gnt == 2'b00; c++) tick();
            w = rr_pick(pat, ptr_m);
            ptr_m = (w + 1) % N;
            total++; if (arb_gnt !== 2'(1 << w)) begin bad++; $display("FAIL rr_gnt it=%0d got=%b want=%b", it, arb_gnt, 2'(1 << w)); end
            req_Addr = {$urandom, $urandom};
            req_WrFIFO_Data = {$urandom, $urandom};
            req_Size = 8'($urandom);
            v = 1'($urandom);
            PIM_WrFIFO_AlmostFull = v;
            exp_af = 2'b11; exp_af[w] = v;
            #1;
            total++; if (PIM_Addr !== req_Addr[w*32 +: 32]) begin bad++; $display("FAIL rr_addr it=%0d got=%h want=%h", it, PIM_Addr, req_Addr[w*32 +: 32]); end
            total++; if (PIM_WrFIFO_Data !== req_WrFIFO_Data[w*32 +: 32] || PIM_Size !== req_Size[w*4 +: 4]) begin bad++; $display("FAIL rr_data it=%0d got=%h/%h", it, PIM_WrFIFO_Data, PIM_Size); end
            total++; if (req_WrFIFO_AlmostFull !== exp_af) begin bad++; $display("FAIL rr_afull it=%0d got=%b want=%b", it, req_WrFIFO_AlmostFull, exp_af); end
            nack = $urandom_range(0, 5);
            for (int a = 0; a < nack; a++) begin
                PIM_AddrAck = 1; tick(); PIM_AddrAck = 0;
            end
            total++; if (arb_state[15:8] !== 8'(nack) || arb_state[5:4] !== 2'(w)) begin bad++; $display("FAIL rr_cnt it=%0d got=%h want cnt=%0d own=%0d", it, arb_state, nack, w); end
            arb_req[w] = 1'b0;
            tick();
            total++; if (arb_gnt !== 2'b00 || PIM_Addr !== 32'h0) begin bad++; $display("FAIL rr_gap it=%0d got=%b/%h want=00/0", it, arb_gnt, PIM_Addr); end
            arb_req = 0;
            tick();
        end
        PIM_WrFIFO_AlmostFull = 0;
    endtask

    task automatic test_flush;
        do_reset();
        arb_req = 2'b10;
        tick();
        total++; if (arb_gnt !== 2'b10) begin bad++; $display("FAIL fl_gnt got=%b want=10", arb_gnt); end
        for (int i = 0; i < 4; i++) begin
            req_WrFIFO_Push = 2'b10;
            req_WrFIFO_Data = {32'hC0DE_0000 + 32'(i), 32'h0};
            #1;
            total++; if (PIM_WrFIFO_Push !== 1'b1 || PIM_WrFIFO_Data !== 32'hC0DE_0000 + 32'(i)) begin bad++; $display("FAIL fl_push%0d got=%b/%h", i, PIM_WrFIFO_Push, PIM_WrFIFO_Data); end
            tick();
        end
        PIM_WrFIFO_Empty = 0;
        arb_req = 2'b01;
        tick();
        total++; if (PIM_WrFIFO_Flush !== 1'b1 || PIM_RdFIFO_Flush !== 1'b0) begin bad++; $display("FAIL fl_pulse got=%b/%b want=1/0", PIM_WrFIFO_Flush, PIM_RdFIFO_Flush); end
        total++; if (PIM_WrFIFO_Push !== 1'b0 || arb_gnt !== 2'b00) begin bad++; $display("FAIL fl_gap_push got=%b/%b want=0/00", PIM_WrFIFO_Push, arb_gnt); end
        req_WrFIFO_Push = 0;
        tick();
        total++; if (PIM_WrFIFO_Flush !== 1'b0) begin bad++; $display("FAIL fl_once got=%b want=0", PIM_WrFIFO_Flush); end
        total++; if (arb_state[16] !== 1'b1 || arb_state[1:0] !== 2'd2) begin bad++; $display("FAIL fl_sticky got=%h want b16=1 fsm=2", arb_state); end
        tick();
        total++; if (arb_gnt !== 2'b00) begin bad++; $display("FAIL fl_wait got=%b want=00", arb_gnt); end
        PIM_WrFIFO_Empty = 1;
        tick();
        tick();
        total++; if (arb_gnt !== 2'b01) begin bad++; $display("FAIL fl_next got=%b want=01", arb_gnt); end
    endtask

    task automatic test_reset_mid_grant;
        req_AddrReq = 2'b01;
        #1;
        total++; if (PIM_AddrReq !== 1'b1 || arb_state[16] !== 1'b1) begin bad++; $display("FAIL rst_pre got=%b/%h", PIM_AddrReq, arb_state); end
        sys_rst_n = 0;
        #1;
        total++; if (PIM_AddrReq !== 1'b0 || arb_gnt !== 2'b00) begin bad++; $display("FAIL rst_async got=%b/%b want=0/00", PIM_AddrReq, arb_gnt); end
        total++; if (arb_state !== 32'h0) begin bad++; $display("FAIL rst_state got=%h want=0", arb_state); end
        tick();
        sys_rst_n = 1;
        clear_inputs();
    endtask

    task automatic test_isolation;
        do_reset();
        arb_req = 2'b01;
        tick();
        req_AddrReq = 2'b10; req_WrFIFO_Push = 2'b10; req_RdFIFO_Pop = 2'b10;
        PIM_RdFIFO_Empty = 0;
        #1;
        total++; if (PIM_AddrReq !== 0 || PIM_WrFIFO_Push !== 0 || PIM_RdFIFO_Pop !== 0) begin bad++; $display("FAIL iso_strobes got=%b%b%b want=000", PIM_AddrReq, PIM_WrFIFO_Push, PIM_RdFIFO_Pop); end
        total++; if (req_RdFIFO_Empty !== 2'b10 || req_WrFIFO_AlmostFull !== 2'b10) begin bad++; $display("FAIL iso_status got=%b/%b want=10/10", req_RdFIFO_Empty, req_WrFIFO_AlmostFull); end
        req_AddrReq = 2'b11;
        #1;
        total++; if (PIM_AddrReq !== 1'b1) begin bad++; $display("FAIL iso_owner got=%b want=1", PIM_AddrReq); end
        req_AddrReq = 0; req_WrFIFO_Push = 0; req_RdFIFO_Pop = 0;
        PIM_RdFIFO_Empty = 1;
        PIM_AddrAck = 1;
        repeat (260) tick();
        PIM_AddrAck = 0;
        total++; if (arb_state[15:8] !== 8'hFF) begin bad++; $display("FAIL ack_sat got=%h want=ff", arb_state[15:8]); end
        arb_req = 0;
        repeat (3) tick();
    endtask

    task automatic test_hold_timeout;
        int held;
        do_reset();
        arb_req = 2'b11;
        tick();
        total++; if (arb_gnt !== 2'b01) begin bad++; $display("FAIL to_gnt got=%b want=01", arb_gnt); end
        held = 1;
        for (int c = 0; c < 40 && arb_gnt == 2'b01; c++) begin
            tick();
            if (arb_gnt == 2'b01) held++;
        end
`ifdef SATA_PIM_ARB_TIMEOUT_EN
        total++; if (held !== 16) begin bad++; $display("FAIL to_len got=%0d want=16", held); end
        total++; if (arb_state[17] !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b want=1", arb_state[17]); end
        for (int c = 0; c < 8 && arb_gnt == 2'b00; c++) tick();
        total++; if (arb_gnt !== 2'b10) begin bad++; $display("FAIL to_next got=%b want=10", arb_gnt); end
`else
        total++; if (held !== 41) begin bad++; $display("FAIL hold_len got=%0d want=41", held); end
        total++; if (arb_state[17] !== 1'b0) begin bad++; $display("FAIL hold_sticky got=%b want=0", arb_state[17]); end
`endif
        arb_req = 0;
        repeat (3) tick();
    endtask

    initial begin
        clear_inputs();
        sys_rst_n = 0;
        test_reset();
        test_basic_grant();
        test_alternate();
        test_random_rr();
        test_isolation();
        test_flush();
        test_reset_mid_grant();
        test_hold_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sata_pim_arb.md
Name: sata_pim_arb

Overview:
- Shares one MPMC PIM port between C_NUM_PORTS SATA port DMA engines; each engine's PIM interface connects here instead of to the MPMC.
- Requesters arbitrate with a req/gnt pair and round-robin priority.
- The owner's PIM signals pass through to the MPMC; the MPMC status returns only to the owner.
- On release, the arbiter cleans up any residual PIM FIFO data before the next grant.

Parameters:
- C_NUM_PORTS, 2, number of requesting DMA engines (1..4).
- C_TIMEOUT, 4095, grant-hold watchdog limit in sys_clk cycles (only with the optional feature).

Ports:
- sys_clk  in  1  PIM/MPMC clock; everything here is synchronous to it.
- sys_rst_n  in  1  asynchronous active-low reset.
- arb_req  in  N  per-port ownership request, level.
- arb_gnt  out  N  one-hot grant.
- req_Addr, req_AddrReq, req_RNW, req_Size, req_RdModWr, req_RdFIFO_Pop, req_RdFIFO_Flush, req_WrFIFO_Data, req_WrFIFO_BE, req_WrFIFO_Push, req_WrFIFO_Flush  in  per-port concatenations, widths 32N/N/N/4N/N/N/N/32N/4N/N/N  requester PIM outputs.
- req_AddrAck, req_RdFIFO_Empty, req_WrFIFO_AlmostFull  out  N each  per-port PIM status.
- req_RdFIFO_Data  out  32  broadcast read data (valid only to owner).
- PIM_Addr, PIM_AddrReq, PIM_RNW, PIM_Size, PIM_RdModWr, PIM_RdFIFO_Pop, PIM_RdFIFO_Flush, PIM_WrFIFO_Data, PIM_WrFIFO_BE, PIM_WrFIFO_Push, PIM_WrFIFO_Flush  out  32/1/1/4/1/1/1/32/4/1/1  to MPMC.
- PIM_AddrAck, PIM_RdFIFO_Empty, PIM_WrFIFO_Empty, PIM_WrFIFO_AlmostFull, PIM_InitDone  in  1 each  from MPMC.
- PIM_RdFIFO_Data  in  32  from MPMC.
- arb_state  out  32  debug: [1:0] fsm, [5:4] owner, [15:8] AddrAck count in current grant, [16] residual-flush sticky, [17] timeout sticky.

Behaviour:
- Reset values:
  - arb_gnt = 0; all PIM_* outputs = 0; req_AddrAck = 0.
  - req_RdFIFO_Empty = all 1; req_WrFIFO_AlmostFull = all 1.
  - RR pointer = 0; arb_state = 0.
- FSM states: IDLE(0), GRANT(1), GAP(2).
- IDLE:
  - Requires PIM_InitDone = 1; otherwise stay in IDLE.
  - If any arb_req is set, pick the first set bit searching from the pointer upward with wrap.
  - Register arb_gnt one-hot next cycle (1-cycle req->gnt latency) and go to GRANT.
  - Pointer = winner + 1 mod N.
- GRANT:
  - Owner's req_* inputs drive PIM_* outputs combinationally from the registered owner index.
  - Owner receives PIM_AddrAck, PIM_RdFIFO_Empty and PIM_WrFIFO_AlmostFull.
  - Non-owners see AddrAck = 0, RdFIFO_Empty = 1, WrFIFO_AlmostFull = 1.
  - A non-owner's AddrReq/Push/Pop is ignored and never reaches the MPMC.
  - AddrAck count increments per PIM_AddrAck, saturating at 255.
  - When the owner drops arb_req: arb_gnt clears the next cycle and the FSM goes to GAP.
  - No preemption; ownership persists across any number of transactions.
- GAP (1 cycle minimum):
  - All PIM_* outputs forced to 0 except the flush strobes.
  - If PIM_RdFIFO_Empty = 0: pulse PIM_RdFIFO_Flush for 1 cycle and set sticky [16].
  - If PIM_WrFIFO_Empty = 0: pulse PIM_WrFIFO_Flush for 1 cycle and set sticky [16].
  - Remain in GAP until both FIFOs report empty, then go to IDLE.
  - An arb_req seen in GAP is arbitrated in IDLE.
- Simultaneous release and new request: the new request waits for the GAP to finish; the released port is lowest priority per the pointer.
- Owner reasserts arb_req after release: it is treated as a new request.
- PIM_InitDone falling while in GRANT: no forced release; the owner is responsible.
- Reset mid-grant: every output returns to its reset value immediately (async). Sticky bits clear only on reset.
- N = 1: the pointer stays 0; the FSM is unchanged.

Optional Feature:
- Macro: SATA_PIM_ARB_TIMEOUT_EN.
- With the macro:
  - A 12-bit counter clears on entering GRANT and increments each GRANT cycle in which PIM_AddrAck = 0 and no Push/Pop occurs.
  - On reaching C_TIMEOUT, the arbiter forcibly clears arb_gnt, sets sticky [17] and goes to GAP (flushing residue as above).
  - The timed-out port must drop and reassert arb_req to be granted again.
- Without the macro: no counter; [17] reads 0; grants are held indefinitely.

Test Plan:
- Reset, then PIM_InitDone = 1, arb_req = 2'b01 -> arb_gnt = 01 one cycle later; PIM_Addr follows req_Addr[31:0] (0x1000_0000); req_AddrAck[1] never set.
- arb_req = 2'b11 held, each owner releasing after one AddrAck -> grants alternate 01, 10, 01 with exactly one GAP cycle between them; pointer wraps.
- Port1 pushes 4 write words and releases before AddrReq (PIM_WrFIFO_Empty = 0) -> PIM_WrFIFO_Flush pulses once in GAP; arb_state[16] = 1; next grant only after Empty = 1.
- Port0 granted while port1 asserts req_AddrReq = 1 and req_WrFIFO_Push = 1 -> PIM_AddrReq and PIM_WrFIFO_Push reflect only port0; port1 sees RdFIFO_Empty = 1 and AlmostFull = 1.
- With SATA_PIM_ARB_TIMEOUT_EN and C_TIMEOUT = 16: port0 granted and idle -> arb_gnt drops after 16 cycles, arb_state[17] = 1, port1 granted next if requesting.
- Assert sys_rst_n = 0 mid-GRANT with PIM_AddrReq = 1 -> PIM_AddrReq = 0, arb_gnt = 0 and arb_state = 0 asynchronously.
